gin_mc_bus_buffered: RTL and testbench

//  Global-input-network multicast bus, buffered generation. One source word carrying a tag
//  is delivered to every target whose scan-programmed ID matches, via per-target FIFOs.

---
 rtl/gin_mc_bus_buffered.sv | 133 +++++++++++++
 tb/tb_gin_mc_bus_buffered.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gin_mc_bus_buffered.sv
// Global-input-network multicast bus, buffered generation.
// A tagged source word is written atomically into the FIFO of every target
// whose scan-programmed ID matches the tag. An all-ones tag can be enabled as
// a broadcast. Words that match no target are consumed and counted in a
// saturating drop counter.
// The scan-program control is named program_en because "program" is a
// reserved SystemVerilog keyword and cannot be used as a port name.
module gin_mc_bus_buffered #(
    parameter int BITWIDTH        = 16,
    parameter int TAG_LENGTH      = 4,
    parameter int NUM_CONTROLLERS = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int BCAST_EN        = 1,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                program_en,
    input  logic [TAG_LENGTH-1:0]               scan_tag_in,
    output logic [TAG_LENGTH-1:0]               scan_tag_out,
    input  logic                                src_valid,
    output logic                                src_ready,
    input  logic [TAG_LENGTH-1:0]               src_tag,
    input  logic [BITWIDTH-1:0]                 src_data,
    output logic [NUM_CONTROLLERS-1:0]          tgt_valid,
    input  logic [NUM_CONTROLLERS-1:0]          tgt_ready,
    output logic [BITWIDTH*NUM_CONTROLLERS-1:0] tgt_data,
    output logic                                bus_idle,
    output logic [CNT_WIDTH-1:0]                drop_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [OCC_W-1:0]      OCC_FULL  = OCC_W'(FIFO_DEPTH);
    localparam logic [TAG_LENGTH-1:0] BCAST_TAG = '1;

    logic [TAG_LENGTH-1:0] ids    [NUM_CONTROLLERS];
    logic [BITWIDTH-1:0]   mem    [NUM_CONTROLLERS][FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr [NUM_CONTROLLERS];
    logic [PTR_W-1:0]      rd_ptr [NUM_CONTROLLERS];
    logic [OCC_W-1:0]      occ    [NUM_CONTROLLERS];

    logic [NUM_CONTROLLERS-1:0] match;
    logic [NUM_CONTROLLERS-1:0] full;
    logic [NUM_CONTROLLERS-1:0] nonempty;
    logic [NUM_CONTROLLERS-1:0] push;
    logic [NUM_CONTROLLERS-1:0] pop;
    logic                       accept;
    logic                       drop;

    // Tag match, FIFO status and the all-or-none accept decision.
    // NOTE: combinational blocks use blocking '=' with a default for every
    // signal first, so no latch is inferred; clocked blocks use '<=' only.
    always_comb begin
        match    = '0;
        full     = '0;
        nonempty = '0;
        for (int i = 0; i < NUM_CONTROLLERS; i++) begin
            match[i]    = (src_tag == ids[i]) ||
                          ((BCAST_EN != 0) && (src_tag == BCAST_TAG));
            full[i]     = (occ[i] == OCC_FULL);
            nonempty[i] = (occ[i] != '0);
        end
        // Full is judged before this cycle's pops: no push-through on a full FIFO.
        src_ready = !rst && !program_en && ((match & full) == '0);
        accept    = src_valid && src_ready;
        push      = accept ? match : '0;
        pop       = tgt_ready & nonempty;
        drop      = accept && (match == '0);
    end

    // ID scan chain: shifts from ID[0] towards ID[N-1] while programming.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CONTROLLERS; i++) ids[i] <= '0;
        end else if (program_en) begin
            ids[0] <= scan_tag_in;
            for (int i = 1; i < NUM_CONTROLLERS; i++) ids[i] <= ids[i-1];
        end
    end

    // Per-target FIFO pointers and occupancy; reset discards all contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CONTROLLERS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                occ[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CONTROLLERS; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                case ({push[i], pop[i]})
                    2'b10:   occ[i] <= occ[i] + OCC_W'(1);
                    2'b01:   occ[i] <= occ[i] - OCC_W'(1);
                    default: occ[i] <= occ[i];
                endcase
            end
        end
    end

    // FIFO storage write port.
    // NOTE: storage is deliberately not reset; emptiness is tracked by the
    // occupancy counters, so stale words are never presented as valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CONTROLLERS; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= src_data;
        end
    end

    // Saturating count of accepted words that matched no target.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if (drop && (drop_count != '1)) begin
            drop_count <= drop_count + CNT_WIDTH'(1);
        end
    end

    // Target-side outputs: FIFO heads, valid flags, idle and scan output.
    always_comb begin
        tgt_data  = '0;
        tgt_valid = '0;
        for (int i = 0; i < NUM_CONTROLLERS; i++) begin
            tgt_data[BITWIDTH*i +: BITWIDTH] = mem[i][rd_ptr[i]];
            tgt_valid[i] = nonempty[i] && !rst;
        end
        bus_idle     = rst || (nonempty == '0);
        scan_tag_out = rst ? '0 : ids[NUM_CONTROLLERS-1];
    end

endmodule

// File: tb/tb_gin_mc_bus_buffered.sv
// Directed self-checking bench for gin_mc_bus_buffered.
// Inputs change 1 time unit after the rising edge; outputs are checked
// 2 time units after the edge, well away from the next edge.
module tb_gin_mc_bus_buffered;

    localparam int BW = 16;
    localparam int TL = 4;
    localparam int NC = 4;
    localparam int CW = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             program_en;
    logic [TL-1:0]    scan_tag_in;
    logic [TL-1:0]    scan_tag_out;
    logic             src_valid;
    logic             src_ready;
    logic [TL-1:0]    src_tag;
    logic [BW-1:0]    src_data;
    logic [NC-1:0]    tgt_valid;
    logic [NC-1:0]    tgt_ready;
    logic [BW*NC-1:0] tgt_data;
    logic             bus_idle;
    logic [CW-1:0]    drop_count;

    int tests_run = 0;
    int tests_failed = 0;

    gin_mc_bus_buffered #(
        .BITWIDTH(BW), .TAG_LENGTH(TL), .NUM_CONTROLLERS(NC),
        .FIFO_DEPTH(4), .BCAST_EN(1), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .program_en(program_en),
        .scan_tag_in(scan_tag_in), .scan_tag_out(scan_tag_out),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_tag(src_tag), .src_data(src_data),
        .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt_data(tgt_data),
        .bus_idle(bus_idle), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; program_en = 1'b0; scan_tag_in = '0;
        src_valid = 1'b0; src_tag = '0; src_data = '0; tgt_ready = '0;

        // ---- Reset state ----
        tick(); tick();
        settle();
        check("rst_tgt_valid", 32'(tgt_valid), 32'h0);
        check("rst_bus_idle", 32'(bus_idle), 32'h1);
        check("rst_src_ready", 32'(src_ready), 32'h0);
        check("rst_scan_out", 32'(scan_tag_out), 32'h0);
        check("rst_drop_count", 32'(drop_count), 32'h0);

        // ---- Scan 4,3,2,1 -> IDs 1,2,3,4 ----
        rst = 1'b0; program_en = 1'b1;
        scan_tag_in = 4'd4; src_tag = 4'd0; src_valid = 1'b1;
        settle();
        check("prog_blocks_src", 32'(src_ready), 32'h0);
        tick(); scan_tag_in = 4'd3;
        tick(); scan_tag_in = 4'd2;
        tick(); scan_tag_in = 4'd1;
        tick();
        program_en = 1'b0; src_valid = 1'b0;
        settle();
        check("scan_out_after_load", 32'(scan_tag_out), 32'h4);
        check("no_push_while_prog", 32'(bus_idle), 32'h1);

        // ---- Unicast tag=2 -> lane 1 ----
        src_valid = 1'b1; src_tag = 4'd2; src_data = 16'hABCD;
        settle();
        check("uni_src_ready", 32'(src_ready), 32'h1);
        tick();
        src_valid = 1'b0;
        settle();
        check("uni_tgt_valid", 32'(tgt_valid), 32'h2);
        check("uni_lane1", 32'(tgt_data[BW*1 +: BW]), 32'hABCD);
        check("uni_not_idle", 32'(bus_idle), 32'h0);
        tgt_ready = 4'b0010;
        tick();
        tgt_ready = 4'b0000;
        settle();
        check("uni_popped", 32'(tgt_valid), 32'h0);
        check("uni_idle", 32'(bus_idle), 32'h1);

        // ---- Broadcast tag=F ----
        src_valid = 1'b1; src_tag = 4'hF; src_data = 16'h1234;
        tick();
        src_valid = 1'b0;
        settle();
        check("bc_tgt_valid", 32'(tgt_valid), 32'hF);
        check("bc_lane0", 32'(tgt_data[BW*0 +: BW]), 32'h1234);
        check("bc_lane1", 32'(tgt_data[BW*1 +: BW]), 32'h1234);
        check("bc_lane2", 32'(tgt_data[BW*2 +: BW]), 32'h1234);
        check("bc_lane3", 32'(tgt_data[BW*3 +: BW]), 32'h1234);
        check("bc_drop_count", 32'(drop_count), 32'h0);
        tgt_ready = 4'b1111;
        tick();
        tgt_ready = 4'b0000;
        settle();
        check("bc_idle", 32'(bus_idle), 32'h1);

        // ---- Unmatched tag=7 x300, saturating drop counter ----
        src_valid = 1'b1; src_tag = 4'd7; src_data = 16'h0777;
        for (int k = 0; k < 300; k++) begin
            settle();
            check("drop_src_ready", 32'(src_ready), 32'h1);
            tick();
        end
        src_valid = 1'b0;
        settle();
        check("drop_saturated", 32'(drop_count), 32'hFF);
        check("drop_fifos_empty", 32'(bus_idle), 32'h1);
        check("drop_tgt_valid", 32'(tgt_valid), 32'h0);

        // ---- Fill FIFO 0, back-pressure, push+pop on full ----
        tgt_ready = 4'b0000; src_tag = 4'd1; src_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            src_data = 16'h1000 + 16'(k);
            tick();
        end
        src_data = 16'h1005;
        settle();
        check("full_stall_tag1", 32'(src_ready), 32'h0);
        src_valid = 1'b0; src_tag = 4'd2;
        settle();
        check("full_other_tag_ok", 32'(src_ready), 32'h1);
        src_valid = 1'b1; src_tag = 4'd1; tgt_ready = 4'b0001;
        settle();
        check("full_pushpop_stall", 32'(src_ready), 32'h0);
        check("full_head_1st", 32'(tgt_data[BW*0 +: BW]), 32'h1001);
        tick();
        tgt_ready = 4'b0000;
        settle();
        check("after_pop_ready", 32'(src_ready), 32'h1);
        tick();
        src_valid = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            settle();
            check("order_valid", 32'(tgt_valid[0]), 32'h1);
            check("order_head", 32'(tgt_data[BW*0 +: BW]), 32'h1000 + 32'(k));
            tgt_ready = 4'b0001;
            tick();
            tgt_ready = 4'b0000;
        end
        settle();
        check("order_drained", 32'(tgt_valid), 32'h0);
        check("order_drop_unchanged", 32'(drop_count), 32'hFF);

        // ---- Reset with three words buffered ----
        src_valid = 1'b1; src_tag = 4'd3;
        for (int k = 0; k < 3; k++) begin
            src_data = 16'h3000 + 16'(k);
            tick();
        end
        src_valid = 1'b0;
        settle();
        check("pre_rst_valid", 32'(tgt_valid), 32'h4);
        rst = 1'b1;
        settle();
        check("mid_rst_src_ready", 32'(src_ready), 32'h0);
        tick();
        settle();
        check("post_rst_tgt_valid", 32'(tgt_valid), 32'h0);
        check("post_rst_idle", 32'(bus_idle), 32'h1);
        check("post_rst_drop", 32'(drop_count), 32'h0);
        rst = 1'b0;
        tick();
        settle();
        check("rst_discard_valid", 32'(tgt_valid), 32'h0);
        check("rst_ids_cleared", 32'(scan_tag_out), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
